// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
//
// Four-floor single-cab elevator controller. Floor calls are latched into a
// pending mask and served with a collective (sweep) policy: the cab keeps
// going in its last direction while calls remain ahead of it, otherwise it
// reverses. All outputs are decoded from registered state only (Moore).
//
// Parameters
//   TRAVEL_CYC     cycles to move between adjacent floors (1..255)
//   DOOR_CYC       cycles the door stays open per stop (1..255)
//   HOME_IDLE_CYC  idle cycles before returning to floor 0 (home-return only)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   call_req[3:0]  per-floor call level, bit i = floor i
//   current_floor  cab floor 0..3
//   direction      00 stopped, 01 moving up, 10 moving down
//   door_open      high while the door is open
//   pending[3:0]   latched outstanding calls
//   busy           high when not idle or any call is pending
//
// Build option
//   ELEV_HOME_RETURN_EN  when defined, an idle cab away from floor 0 with no
//                        pending calls raises an internal call to floor 0
//                        after HOME_IDLE_CYC consecutive idle cycles.
// ---------------------------------------------------------------------------
module elevator_scheduler #(
  parameter int unsigned TRAVEL_CYC    = 4,
  parameter int unsigned DOOR_CYC      = 3,
  parameter int unsigned HOME_IDLE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call_req,
  output logic [1:0] current_floor,
  output logic [1:0] direction,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  // Timers count down to zero, so loading N-1 gives exactly N cycles.
  localparam logic [7:0] TRAVEL_LD = 8'(TRAVEL_CYC - 1);
  localparam logic [7:0] DOOR_LD   = 8'(DOOR_CYC - 1);

  state_t     state, state_nx;
  logic [1:0] floor_q, floor_nx;
  logic       dir_up, dir_up_nx;   // last-direction memory, 1 = up
  logic [3:0] pend_q, pend_nx;
  logic [7:0] tmr, tmr_nx;

  logic [3:0] eff;                 // calls visible to this cycle's decisions
  logic [1:0] arr_floor;           // floor reached when the current move ends
  logic       home_set;

  function automatic logic calls_above(input logic [3:0] v, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  function automatic logic calls_below(input logic [3:0] v, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  assign eff       = pend_q | call_req;
  // Never wraps: a move is only started toward an existing floor.
  assign arr_floor = dir_up ? (floor_q + 2'd1) : (floor_q - 2'd1);

`ifdef ELEV_HOME_RETURN_EN
  localparam logic [7:0] HOME_LD = 8'(HOME_IDLE_CYC - 1);

  logic [7:0] idle_cnt;
  logic       idle_away;

  assign idle_away = (state == ST_IDLE) && (pend_q == 4'b0000) && (floor_q != 2'd0);
  assign home_set  = idle_away && (idle_cnt == HOME_LD);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 8'd0;
    end else if (idle_away && !home_set) begin
      idle_cnt <= idle_cnt + 8'd1;
    end else begin
      idle_cnt <= 8'd0;
    end
  end
`else
  assign home_set = 1'b0;
`endif

  // Next-state, next-timer, next-pending
  always_comb begin
    state_nx  = state;
    floor_nx  = floor_q;
    dir_up_nx = dir_up;
    tmr_nx    = tmr;
    pend_nx   = pend_q | call_req;
    if (home_set) pend_nx[0] = 1'b1;

    case (state)
      ST_IDLE: begin
        if (eff[floor_q]) begin
          state_nx         = ST_DOOR;
          tmr_nx           = DOOR_LD;
          pend_nx[floor_q] = 1'b0;
        end else if (dir_up && calls_above(eff, floor_q)) begin
          state_nx = ST_MOVE;
          tmr_nx   = TRAVEL_LD;
        end else if (!dir_up && calls_below(eff, floor_q)) begin
          state_nx = ST_MOVE;
          tmr_nx   = TRAVEL_LD;
        end else if (calls_above(eff, floor_q)) begin
          state_nx  = ST_MOVE;
          tmr_nx    = TRAVEL_LD;
          dir_up_nx = 1'b1;
        end else if (calls_below(eff, floor_q)) begin
          state_nx  = ST_MOVE;
          tmr_nx    = TRAVEL_LD;
          dir_up_nx = 1'b0;
        end
      end

      ST_MOVE: begin
        if (tmr != 8'd0) begin
          tmr_nx = tmr - 8'd1;
        end else begin
          // Arrival: decide using the floor being reached.
          floor_nx = arr_floor;
          if (eff[arr_floor]) begin
            state_nx           = ST_DOOR;
            tmr_nx             = DOOR_LD;
            pend_nx[arr_floor] = 1'b0;
          end else if (dir_up ? calls_above(eff, arr_floor)
                              : calls_below(eff, arr_floor)) begin
            tmr_nx = TRAVEL_LD;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end

      ST_DOOR: begin
        // A call for the open floor extends the stop instead of latching.
        pend_nx[floor_q] = 1'b0;
        if (call_req[floor_q]) begin
          tmr_nx = DOOR_LD;
        end else if (tmr == 8'd0) begin
          state_nx = ST_IDLE;
        end else begin
          tmr_nx = tmr - 8'd1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
        tmr_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      floor_q <= 2'd0;
      dir_up  <= 1'b1;
      pend_q  <= 4'b0000;
      tmr     <= 8'd0;
    end else begin
      state   <= state_nx;
      floor_q <= floor_nx;
      dir_up  <= dir_up_nx;
      pend_q  <= pend_nx;
      tmr     <= tmr_nx;
    end
  end

  // Output decode from registered state
  assign current_floor = floor_q;
  assign direction     = (state == ST_MOVE) ? (dir_up ? 2'b01 : 2'b10) : 2'b00;
  assign door_open     = (state == ST_DOOR);
  assign pending       = pend_q;
  assign busy          = (state != ST_IDLE) || (pend_q != 4'b0000);

endmodule

// File: tb/tb_elevator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_scheduler
//
// Directed scenarios followed by random call traffic with occasional resets.
// A behavioural model of the cab (floor number, activity, remaining cycles,
// set of outstanding calls) predicts the outputs after every clock edge; the
// predictions are queued by the driver and compared by a separate monitor.
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam int HOME   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] call_req = 4'b0000;
  logic [1:0] current_floor;
  logic [1:0] direction;
  logic       door_open;
  logic [3:0] pending;
  logic       busy;

  elevator_scheduler #(
    .TRAVEL_CYC   (TRAVEL),
    .DOOR_CYC     (DOOR),
    .HOME_IDLE_CYC(HOME)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_req     (call_req),
    .current_floor(current_floor),
    .direction    (direction),
    .door_open    (door_open),
    .pending      (pending),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] floor;
    logic [1:0] dir;
    logic       door;
    logic [3:0] pend;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the cab is doing, how many cycles of that activity
  // remain, which way it last travelled and which floors still want service.
  localparam int IDLE = 0, MOVING = 1, DOORS = 2;
  int  m_floor;
  int  m_mode;
  int  m_left;
  int  m_idle;
  bit  m_up;
  bit  m_want[4];

  function automatic bit any_between(bit v[4], int lo, int hi);
    for (int i = lo; i <= hi; i++) if (i >= 0 && i <= 3 && v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_mode = IDLE; m_left = 0; m_idle = 0; m_up = 1'b1;
    for (int i = 0; i < 4; i++) m_want[i] = 1'b0;
  endtask

  task automatic model_step(input bit r, input logic [3:0] req);
    bit   seen[4];
    bit   nwant[4];
    bit   home;
    bit   any;
    exp_t e;
    if (r) begin
      model_reset();
    end else begin
      home = 1'b0;
      any  = 1'b0;
      for (int i = 0; i < 4; i++) any |= m_want[i];
`ifdef ELEV_HOME_RETURN_EN
      if (m_mode == IDLE && !any && m_floor != 0) begin
        m_idle++;
        if (m_idle == HOME) begin home = 1'b1; m_idle = 0; end
      end else m_idle = 0;
`endif
      for (int i = 0; i < 4; i++) begin
        seen[i]  = m_want[i] | req[i];
        nwant[i] = seen[i];
      end
      if (home) nwant[0] = 1'b1;
      if (m_mode == IDLE) begin
        if (seen[m_floor]) begin
          m_mode = DOORS; m_left = DOOR; nwant[m_floor] = 1'b0;
        end else begin
          bit up_w, dn_w;
          up_w = any_between(seen, m_floor + 1, 3);
          dn_w = any_between(seen, 0, m_floor - 1);
          if ((m_up && up_w) || (!m_up && !dn_w && up_w)) begin
            m_mode = MOVING; m_left = TRAVEL; m_up = 1'b1;
          end else if (dn_w) begin
            m_mode = MOVING; m_left = TRAVEL; m_up = 1'b0;
          end
        end
      end else if (m_mode == MOVING) begin
        m_left--;
        if (m_left == 0) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          if (seen[m_floor]) begin
            m_mode = DOORS; m_left = DOOR; nwant[m_floor] = 1'b0;
          end else if (m_up ? any_between(seen, m_floor + 1, 3)
                            : any_between(seen, 0, m_floor - 1)) begin
            m_left = TRAVEL;
          end else begin
            m_mode = IDLE;
          end
        end
      end else begin
        nwant[m_floor] = 1'b0;
        if (req[m_floor]) m_left = DOOR;
        else begin
          m_left--;
          if (m_left == 0) m_mode = IDLE;
        end
      end
      for (int i = 0; i < 4; i++) m_want[i] = nwant[i];
    end
    e.floor = 2'(m_floor);
    e.dir   = (m_mode == MOVING) ? (m_up ? 2'b01 : 2'b10) : 2'b00;
    e.door  = (m_mode == DOORS);
    for (int i = 0; i < 4; i++) e.pend[i] = m_want[i];
    e.busy  = (m_mode != IDLE) || (e.pend != 4'b0000);
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit r, input logic [3:0] req);
    @(negedge clk);
    rst      = r;
    call_req = req;
    model_step(r, req);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a new output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("current_floor", 32'(current_floor), 32'(e.floor));
        chk("direction",     32'(direction),     32'(e.dir));
        chk("door_open",     32'(door_open),     32'(e.door));
        chk("pending",       32'(pending),       32'(e.pend));
        chk("busy",          32'(busy),          32'(e.busy));
      end
    end
  end

  initial begin
    logic [3:0] rq;
    bit         rr;
    int         guard;
    model_reset();

    // Reset state, then a single call two floors up
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b1111);
    tick(1'b0, 4'b0100);
    repeat (20) tick(1'b0, 4'b0000);

    // At floor 2 heading up: calls above and below in the same cycle
    tick(1'b0, 4'b1001);
    repeat (36) tick(1'b0, 4'b0000);

    // From floor 0 toward 3, with an intermediate call during the first hop
    tick(1'b0, 4'b1000);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0010);
    repeat (30) tick(1'b0, 4'b0000);

    // Door open at floor 1, same-floor call repeated on door cycle 2
    tick(1'b0, 4'b0010);
    for (int k = 0; k < 100 && m_mode != DOORS; k++) tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0010);
    repeat (8) tick(1'b0, 4'b0000);

    // Same-floor call while idle opens the door next cycle
    tick(1'b0, 4'(1 << m_floor));
    repeat (6) tick(1'b0, 4'b0000);

    // Reset in the middle of a move, with calls present during reset
    tick(1'b0, 4'b1000);
    repeat (6) tick(1'b0, 4'b0000);
    tick(1'b1, 4'b1111);
    repeat (3) tick(1'b0, 4'b0000);

    // Long idle away from floor 0
    tick(1'b0, 4'b1000);
    repeat (40) tick(1'b0, 4'b0000);

    // Random traffic
    repeat (4000) begin
      rr = ($urandom_range(0, 599) == 0);
      rq = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tick(rr, rq);
    end
    repeat (60) tick(1'b0, 4'b0000);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
